// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states,
// CAUSE layout and the priority-encoder helper.
package irq_ctrl_pkg;

    // Word addresses of the Wishbone-visible registers
    localparam logic [1:0] ADR_PENDING = 2'd0;
    localparam logic [1:0] ADR_MASK    = 2'd1;
    localparam logic [1:0] ADR_EDGE    = 2'd2;
    localparam logic [1:0] ADR_CAUSE   = 2'd3;

    // CAUSE register layout: busy flag at the top, source id at the bottom
    localparam int CAUSE_BUSY_BIT = 31;
    localparam int ID_W           = 3;

    // Largest number of sources an id of ID_W bits can name
    localparam int MAX_SRC = 8;

    // Handshake states towards the CPU
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Priority encoder: lowest set bit wins, returns 0 for an empty vector
    function automatic logic [ID_W-1:0] lowest_index(input logic [MAX_SRC-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser followed by a delay flop, giving a clean level and a
// single-cycle rising-edge pulse for one asynchronous input bit.
module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic meta;
    logic sync;
    logic dly;

    // Metastability chain plus one extra stage remembering the previous level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            dly  <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
            dly  <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~dly;

endmodule

// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller. Conditions each source, keeps the
// PENDING/MASK/EDGE registers, picks the lowest-numbered enabled source and
// runs the Ireq/Iack/EOI handshake with the CPU. Registers are reached over a
// single-cycle-ack Wishbone slave port.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int                 NUM_SRC  = 4,
    parameter logic [NUM_SRC-1:0] MASK_RST = 4'b0001,
    parameter logic [NUM_SRC-1:0] EDGE_RST = 4'b1111
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic [1:0]         wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    input  logic               wb_we_i,
    output logic               wb_ack_o,
    output logic               ireq_o,
    input  logic               iack_i,
    output logic [ID_W-1:0]    irq_id_o
);

    state_t             state;
    logic [NUM_SRC-1:0] src_level;
    logic [NUM_SRC-1:0] src_rise;
    logic               iack_level;
    logic               iack_rise;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] edge_mode;
    logic [NUM_SRC-1:0] req_vec;
    logic [NUM_SRC-1:0] id_hot;
    logic [NUM_SRC-1:0] clr;

    logic               bus_req;
    logic               wr_en;
    logic               pend_wr;
    logic               mask_wr;
    logic               edge_wr;
    logic               eoi;
    logic               auto_clr;
    logic [31:0]        rd_data;
    logic               unused_bits;

    // One synchroniser per interrupt source
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src_sync
        irq_sync_edge u_src_sync (
            .clk   (wb_clk_i),
            .rst_n (wb_rst_n_i),
            .d     (irq_src_i[g]),
            .level (src_level[g]),
            .rise  (src_rise[g])
        );
    end

    // Iack comes from the CPU clock domain, so it is conditioned the same way;
    // only its rising edge matters, so a long Iack counts once
    irq_sync_edge u_iack_sync (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .d     (iack_i),
        .level (iack_level),
        .rise  (iack_rise)
    );

    // Upper write-data bits and the Iack level have no function here
    assign unused_bits = &{1'b0, wb_dat_i[31:NUM_SRC], iack_level};

    // Bus decode: writes land in the cycle where ack is high
    assign bus_req  = wb_stb_i & wb_cyc_i;
    assign wr_en    = wb_ack_o & bus_req & wb_we_i;
    assign pend_wr  = wr_en && (wb_adr_i == ADR_PENDING);
    assign mask_wr  = wr_en && (wb_adr_i == ADR_MASK);
    assign edge_wr  = wr_en && (wb_adr_i == ADR_EDGE);
    assign eoi      = wr_en && (wb_adr_i == ADR_CAUSE);
    assign auto_clr = (state == REQ) && iack_rise;
    assign req_vec  = pending & mask;

    // One-hot form of the latched id, used to auto-clear the acknowledged bit
    always_comb begin
        id_hot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (irq_id_o == ID_W'(i)) begin
                id_hot[i] = 1'b1;
            end
        end
    end

    // Next PENDING: edge sources set on a rise (which beats any clear in the
    // same cycle), level sources simply follow the synchronised input
    always_comb begin
        clr       = (pend_wr  ? wb_dat_i[NUM_SRC-1:0] : '0)
                  | (auto_clr ? id_hot                : '0);
        pending_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (edge_mode[i]) begin
                pending_d[i] = src_rise[i] | (pending[i] & ~clr[i]);
            end else begin
                pending_d[i] = src_level[i];
            end
        end
    end

    // PENDING register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            pending <= '0;
        end else begin
            pending <= pending_d;
        end
    end

    // MASK and EDGE configuration registers, plain read/write
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            mask      <= MASK_RST;
            edge_mode <= EDGE_RST;
        end else begin
            if (mask_wr) begin
                mask <= wb_dat_i[NUM_SRC-1:0];
            end
            if (edge_wr) begin
                edge_mode <= wb_dat_i[NUM_SRC-1:0];
            end
        end
    end

    // Read multiplexer; unimplemented bits read as zero
    always_comb begin
        rd_data = '0;
        case (wb_adr_i)
            ADR_PENDING: rd_data[NUM_SRC-1:0] = pending;
            ADR_MASK:    rd_data[NUM_SRC-1:0] = mask;
            ADR_EDGE:    rd_data[NUM_SRC-1:0] = edge_mode;
            default: begin
                rd_data[CAUSE_BUSY_BIT] = (state == SERVICE);
                rd_data[ID_W-1:0]       = irq_id_o;
            end
        endcase
    end

    // Wishbone response: one ack per request, never back-to-back, with the
    // read data registered alongside it and zero otherwise
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= bus_req & ~wb_ack_o;
            if (bus_req && !wb_ack_o) begin
                wb_dat_o <= rd_data;
            end else begin
                wb_dat_o <= '0;
            end
        end
    end

    // Handshake FSM: once a request is raised its id is frozen until the CPU
    // acknowledges, and nothing new is issued until software writes EOI
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state    <= IDLE;
            ireq_o   <= 1'b0;
            irq_id_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_vec != '0) begin
                        irq_id_o <= lowest_index(MAX_SRC'(req_vec));
                        ireq_o   <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (iack_rise) begin
                        ireq_o <= 1'b0;
                        state  <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    ireq_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed walk through the handshake scenarios, then
// randomised traffic, all compared cycle by cycle against a reference model
// built from input history and plain integer bookkeeping.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  src;
    logic [1:0]  adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        stb;
    logic        cyc;
    logic        we;
    logic        ack;
    logic        ireq;
    logic        iack;
    logic [2:0]  id;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [3:0]  m_pend;
    logic [3:0]  m_mask;
    logic [3:0]  m_edge;
    int          m_phase;
    int          m_id;
    logic        m_ireq;
    logic        m_ack;
    logic [31:0] m_dat;
    logic [3:0]  h1, h2, h3;
    logic        a1, a2, a3;

    logic [31:0] rd;

    always #5 clk = ~clk;

    irq_ctrl dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .irq_src_i  (src),
        .wb_adr_i   (adr),
        .wb_dat_i   (dat_i),
        .wb_dat_o   (dat_o),
        .wb_stb_i   (stb),
        .wb_cyc_i   (cyc),
        .wb_we_i    (we),
        .wb_ack_o   (ack),
        .ireq_o     (ireq),
        .iack_i     (iack),
        .irq_id_o   (id)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'b0, m_pend};
            2'd1:    return {28'b0, m_mask};
            2'd2:    return {28'b0, m_edge};
            default: return {(m_phase == 2), 28'b0, 3'(m_id)};
        endcase
    endfunction

    task automatic model_reset();
        m_pend  = 4'h0;
        m_mask  = 4'b0001;
        m_edge  = 4'hF;
        m_phase = 0;
        m_id    = 0;
        m_ireq  = 1'b0;
        m_ack   = 1'b0;
        m_dat   = 32'h0;
        h1 = 4'h0; h2 = 4'h0; h3 = 4'h0;
        a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
    endtask

    // Advance one clock: update the model from the inputs currently driven,
    // then compare the DUT outputs just after the edge
    task automatic applyStimulus();
        logic [3:0] nxt;
        logic [3:0] req;
        logic       wr;
        logic       irise;
        logic       clr;
        logic       new_ack;
        logic [31:0] new_dat;
        irise   = a2 & ~a3;
        wr      = m_ack && stb && cyc && we;
        req     = m_pend & m_mask;
        nxt     = m_pend;
        new_ack = stb && cyc && !m_ack;
        new_dat = new_ack ? model_read(adr) : 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (m_edge[i]) begin
                clr = (wr && adr == ADR_PENDING && dat_i[i]) || (m_phase == 1 && irise && m_id == i);
                nxt[i] = (h2[i] & ~h3[i]) ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
            end else begin
                nxt[i] = h2[i];
            end
        end
        if (m_phase == 0 && req != 4'h0) begin
            for (int i = 3; i >= 0; i--) if (req[i]) m_id = i;
            m_ireq  = 1'b1;
            m_phase = 1;
        end else if (m_phase == 1 && irise) begin
            m_ireq  = 1'b0;
            m_phase = 2;
        end else if (m_phase == 2 && wr && adr == ADR_CAUSE) begin
            m_phase = 0;
        end
        m_pend = nxt;
        if (wr && adr == ADR_MASK) m_mask = dat_i[3:0];
        if (wr && adr == ADR_EDGE) m_edge = dat_i[3:0];
        m_ack = new_ack;
        m_dat = new_dat;
        h3 = h2; h2 = h1; h1 = src;
        a3 = a2; a2 = a1; a1 = iack;
        @(posedge clk);
        #1;
        checkOutput("ack", 32'(ack), 32'(m_ack));
        checkOutput("rdata", dat_o, m_dat);
        checkOutput("ireq", 32'(ireq), 32'(m_ireq));
        checkOutput("irq_id", 32'(id), 32'(m_id));
    endtask

    task automatic busTransfer(input logic [1:0] a, input logic w, input logic [31:0] d,
                               output logic [31:0] data);
        adr   = a;
        we    = w;
        dat_i = d;
        stb   = 1'b1;
        cyc   = 1'b1;
        applyStimulus();
        data = dat_o;
        applyStimulus();
        stb = 1'b0;
        cyc = 1'b0;
        we  = 1'b0;
    endtask

    task automatic serviceAndEoi();
        logic [31:0] unused_rd;
        iack = 1'b1;
        repeat (3) applyStimulus();
        iack = 1'b0;
        repeat (2) applyStimulus();
        busTransfer(ADR_CAUSE, 1'b1, 32'h0, unused_rd);
    endtask

    initial begin
        rst_n = 1'b0;
        src   = 4'h0;
        adr   = 2'd0;
        dat_i = 32'h0;
        stb   = 1'b0;
        cyc   = 1'b0;
        we    = 1'b0;
        iack  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("rst_ireq", 32'(ireq), 32'h0);

        $display("[TB] reset defaults");
        busTransfer(ADR_PENDING, 1'b0, 32'h0, rd); checkOutput("rst_pending", rd, 32'h0);
        busTransfer(ADR_MASK,    1'b0, 32'h0, rd); checkOutput("rst_mask", rd, 32'h1);
        busTransfer(ADR_EDGE,    1'b0, 32'h0, rd); checkOutput("rst_edge", rd, 32'hF);
        busTransfer(ADR_CAUSE,   1'b0, 32'h0, rd); checkOutput("rst_cause", rd, 32'h0);

        $display("[TB] single edge source");
        src = 4'b0001;
        applyStimulus();
        src = 4'b0000;
        repeat (2) applyStimulus();
        checkOutput("lat_ireq_early", 32'(ireq), 32'h0);
        applyStimulus();
        checkOutput("lat_ireq", 32'(ireq), 32'h1);
        checkOutput("lat_id", 32'(id), 32'h0);
        iack = 1'b1;
        repeat (5) applyStimulus();
        iack = 1'b0;
        checkOutput("iack_ireq", 32'(ireq), 32'h0);
        busTransfer(ADR_PENDING, 1'b0, 32'h0, rd); checkOutput("iack_pending", rd, 32'h0);
        busTransfer(ADR_CAUSE,   1'b0, 32'h0, rd); checkOutput("iack_cause", rd, 32'h8000_0000);
        busTransfer(ADR_CAUSE,   1'b1, 32'h0, rd);
        busTransfer(ADR_CAUSE,   1'b0, 32'h0, rd); checkOutput("eoi_cause", rd, 32'h0);

        $display("[TB] priority and queueing");
        busTransfer(ADR_MASK, 1'b1, 32'hF, rd);
        src = 4'b1010;
        applyStimulus();
        src = 4'b0000;
        repeat (3) applyStimulus();
        checkOutput("prio_ireq", 32'(ireq), 32'h1);
        checkOutput("prio_id", 32'(id), 32'h1);
        serviceAndEoi();
        applyStimulus();
        checkOutput("queue_ireq", 32'(ireq), 32'h1);
        checkOutput("queue_id", 32'(id), 32'h3);
        busTransfer(ADR_PENDING, 1'b0, 32'h0, rd); checkOutput("queue_pending", rd, 32'h8);
        serviceAndEoi();

        $display("[TB] mask gating");
        busTransfer(ADR_MASK, 1'b1, 32'h1, rd);
        src = 4'b0100;
        applyStimulus();
        src = 4'b0000;
        repeat (4) applyStimulus();
        checkOutput("gate_ireq", 32'(ireq), 32'h0);
        busTransfer(ADR_PENDING, 1'b0, 32'h0, rd); checkOutput("gate_pending", rd, 32'h4);
        busTransfer(ADR_MASK, 1'b1, 32'h5, rd);
        applyStimulus();
        checkOutput("unmask_ireq", 32'(ireq), 32'h1);
        checkOutput("unmask_id", 32'(id), 32'h2);
        serviceAndEoi();

        $display("[TB] level mode");
        busTransfer(ADR_EDGE, 1'b1, 32'hE, rd);
        src = 4'b0001;
        repeat (4) applyStimulus();
        checkOutput("lvl_ireq", 32'(ireq), 32'h1);
        checkOutput("lvl_id", 32'(id), 32'h0);
        busTransfer(ADR_PENDING, 1'b1, 32'h1, rd);
        busTransfer(ADR_PENDING, 1'b0, 32'h0, rd); checkOutput("lvl_w1c_ignored", rd, 32'h1);
        serviceAndEoi();
        applyStimulus();
        checkOutput("lvl_rereq", 32'(ireq), 32'h1);
        checkOutput("lvl_rereq_id", 32'(id), 32'h0);
        src = 4'b0000;
        repeat (3) applyStimulus();
        serviceAndEoi();
        repeat (2) applyStimulus();
        checkOutput("lvl_quiet", 32'(ireq), 32'h0);

        $display("[TB] W1C race with new edge");
        busTransfer(ADR_EDGE, 1'b1, 32'hF, rd);
        busTransfer(ADR_MASK, 1'b1, 32'h0, rd);
        src = 4'b0010;
        applyStimulus();
        src = 4'b0000;
        busTransfer(ADR_PENDING, 1'b1, 32'h2, rd);
        busTransfer(ADR_PENDING, 1'b0, 32'h0, rd); checkOutput("race_set_wins", rd, 32'h2);
        busTransfer(ADR_PENDING, 1'b1, 32'h2, rd);
        busTransfer(ADR_PENDING, 1'b0, 32'h0, rd); checkOutput("w1c_clears", rd, 32'h0);

        $display("[TB] async reset mid-request");
        busTransfer(ADR_MASK, 1'b1, 32'hF, rd);
        src = 4'b0001;
        applyStimulus();
        src = 4'b0000;
        repeat (3) applyStimulus();
        checkOutput("pre_rst_ireq", 32'(ireq), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ireq", 32'(ireq), 32'h0);
        checkOutput("async_rst_id", 32'(id), 32'h0);
        checkOutput("async_rst_ack", 32'(ack), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        busTransfer(ADR_PENDING, 1'b0, 32'h0, rd); checkOutput("post_rst_pending", rd, 32'h0);
        busTransfer(ADR_MASK,    1'b0, 32'h0, rd); checkOutput("post_rst_mask", rd, 32'h1);
        busTransfer(ADR_EDGE,    1'b0, 32'h0, rd); checkOutput("post_rst_edge", rd, 32'hF);
        busTransfer(ADR_CAUSE,   1'b0, 32'h0, rd); checkOutput("post_rst_cause", rd, 32'h0);

        $display("[TB] randomised traffic");
        busTransfer(ADR_MASK, 1'b1, 32'($urandom_range(0, 15)), rd);
        for (int n = 0; n < 600; n++) begin
            int r;
            r   = $urandom_range(0, 99);
            src = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if (m_ireq && $urandom_range(0, 2) == 0) iack = 1'b1;
            else if ($urandom_range(0, 1) == 0) iack = 1'b0;
            if (r < 10)      busTransfer(ADR_CAUSE, 1'b1, 32'h0, rd);
            else if (r < 14) busTransfer(ADR_MASK, 1'b1, $urandom, rd);
            else if (r < 17) busTransfer(ADR_EDGE, 1'b1, $urandom, rd);
            else if (r < 22) busTransfer(ADR_PENDING, 1'b1, $urandom, rd);
            else if (r < 32) busTransfer(2'($urandom_range(0, 3)), 1'b0, 32'h0, rd);
            else             applyStimulus();
        end
        src  = 4'h0;
        iack = 1'b0;
        repeat (4) applyStimulus();
        busTransfer(ADR_PENDING, 1'b0, 32'h0, rd);
        busTransfer(ADR_MASK,    1'b0, 32'h0, rd);
        busTransfer(ADR_EDGE,    1'b0, 32'h0, rd);
        busTransfer(ADR_CAUSE,   1'b0, 32'h0, rd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
